pwm_fade_sched: RTL

- Upstream feeder for the LED-panel PWM stage.
- Holds a per-output target duty (window width). Fades the current duties toward their targets at a fixed rate.
- Builds the cumulative compare array, NUM_OUTPUTS+1 entries, that the PWM stage consumes. Output i of that stage is on while its counter lies in [compare[i], compare[i+1]).
- Compare updates only at the PWM period boundary, so a period never mixes old and new thresholds.

---
 rtl/pwm_fade_pkg.sv | 39 +++
 rtl/pwm_fade_step.sv | 56 +++++
 rtl/pwm_fade_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg -- shared types and helpers for the PWM fade scheduler.
//
// Contents:
//   fsm_state_t  scheduler state (IDLE, ACCUM)
//   duty_t       wide unsigned container for any legal duty plus one carry bit
//   idx_width()  width of an output index, never below 1
//   sat_add()    add two duties and clamp the sum to the counter maximum
//
// CTR_LEN is limited to MAX_CTR_LEN. This keeps the duty_t container wide
// enough for any legal sum.
package pwm_fade_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } fsm_state_t;

  localparam int MAX_CTR_LEN = 16;

  // One bit wider than the largest duty, so a+b of two duties never wraps.
  typedef logic [MAX_CTR_LEN:0] duty_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The (CTR_LEN+1)-bit sum clamps to 2**ctr_len-1. The callers feed the
  // clamped value back in as the running accumulator. Once it hits the top,
  // it stays there. This gives zero-width windows for every later output.
  function automatic duty_t sat_add(input duty_t a, input duty_t b,
                                    input int ctr_len);
    duty_t sum;
    duty_t lim;
    sum = a + b;
    lim = duty_t'((1 << ctr_len) - 1);
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/pwm_fade_step.sv
// pwm_fade_step -- combinational step of one current duty toward its target.
//
// Ports:
//   i_cur  [CTR_LEN]  current (linear) duty
//   i_tgt  [CTR_LEN]  target duty
//   i_imm  1          jump straight to target, no fading
//   o_nxt  [CTR_LEN]  next current duty
//   o_eff  [CTR_LEN]  effective window width contributed by o_nxt
//
// Optional build macro: PWM_FADE_GAMMA_EN.
//   Defined:   o_eff = (o_nxt*o_nxt) >> CTR_LEN, a square-law brightness curve.
//   Undefined: o_eff = o_nxt.
// Fading always runs on the linear value. Gamma only shapes the window width.
module pwm_fade_step
  import pwm_fade_pkg::*;
#(
  parameter int CTR_LEN   = 8,
  parameter int FADE_STEP = 1
) (
  input  logic [CTR_LEN-1:0] i_cur,
  input  logic [CTR_LEN-1:0] i_tgt,
  input  logic               i_imm,
  output logic [CTR_LEN-1:0] o_nxt,
  output logic [CTR_LEN-1:0] o_eff
);

  // The truncation is used only when the distance exceeds FADE_STEP. In
  // that case FADE_STEP < 2**CTR_LEN, so it is exact.
  localparam logic [CTR_LEN-1:0] STEP = CTR_LEN'(FADE_STEP);

  logic               w_up;
  logic [CTR_LEN-1:0] w_diff;

  always_comb begin
    w_up   = (i_tgt > i_cur);
    w_diff = w_up ? (i_tgt - i_cur) : (i_cur - i_tgt);
    if (i_imm)
      o_nxt = i_tgt;
    else if (int'(w_diff) <= FADE_STEP)
      o_nxt = i_tgt;                       // last partial step lands exactly
    else if (w_up)
      o_nxt = i_cur + STEP;
    else
      o_nxt = i_cur - STEP;
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [2*CTR_LEN-1:0] w_ext;
  assign w_ext = {{CTR_LEN{1'b0}}, o_nxt};
  // Keep the upper half of the square: 128*128 >> 8 = 64 for CTR_LEN=8.
  assign o_eff = CTR_LEN'((w_ext * w_ext) >> CTR_LEN);
`else
  assign o_eff = o_nxt;
`endif

endmodule

// File: rtl/pwm_fade_sched.sv
// pwm_fade_sched -- target/fade scheduler feeding the LED-panel PWM stage.
//
// Keeps a target duty per time-sliced output. Once every FADE_DIV PWM
// periods, it walks the outputs one per cycle. On each visit it moves the
// current duty toward its target and rebuilds the cumulative compare array
// into a shadow copy. The shadow reaches the compare output only at a PWM
// period boundary, so the downstream stage never sees a half-updated table.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset (same reset as the PWM stage)
//   wr_valid      target-write request
//   wr_ready      write accepted when wr_valid && wr_ready (low during a pass)
//   wr_idx        output index; out-of-range indices are accepted and dropped
//   wr_duty       target window width
//   wr_immediate  the next pass jumps current to target with no fading
//   compare       [NUM_OUTPUTS:0] x CTR_LEN thresholds; output i is on for
//                 counter values in [compare[i], compare[i+1])
//   period_start  one-cycle pulse after the mirrored counter wraps max->0
//   busy          high while a fade pass (ACCUM) is running
//
// Optional build macro: PWM_FADE_GAMMA_EN (square-law effective duty, see
// pwm_fade_step).
module pwm_fade_sched
  import pwm_fade_pkg::*;
#(
  parameter int CTR_LEN     = 8,
  parameter int NUM_OUTPUTS = 1,
  parameter int FADE_DIV    = 4,
  parameter int FADE_STEP   = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [idx_width(NUM_OUTPUTS)-1:0]   wr_idx,
  input  logic [CTR_LEN-1:0]                  wr_duty,
  input  logic                                wr_immediate,
  output logic [NUM_OUTPUTS:0][CTR_LEN-1:0]   compare,
  output logic                                period_start,
  output logic                                busy
);

  localparam int                IW       = idx_width(NUM_OUTPUTS);
  localparam logic [7:0]        DIV_LAST = 8'(FADE_DIV - 1);
  localparam logic [IW-1:0]     I_LAST   = IW'(NUM_OUTPUTS - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CTR_LEN-1:0]                  r_ctr;          // mirror of PWM counter
  logic [7:0]                          r_div;          // periods since last pass
  logic                                r_period_start;

  fsm_state_t                          r_state;
  logic                                r_busy;
  logic [IW-1:0]                       r_i;            // output being visited
  logic [CTR_LEN-1:0]                  r_acc;          // running, clamped sum

  logic [NUM_OUTPUTS-1:0][CTR_LEN-1:0] r_cur;
  logic [NUM_OUTPUTS-1:0][CTR_LEN-1:0] r_tgt;
  logic [NUM_OUTPUTS-1:0]              r_imm;

  // The shadow's entry 0 is always zero, so only entries 1..N are stored.
  logic [NUM_OUTPUTS:1][CTR_LEN-1:0]   r_shadow;
  logic                                r_shadow_vld;
  logic [NUM_OUTPUTS:0][CTR_LEN-1:0]   r_compare;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic               w_boundary;
  logic               w_tick;
  logic               w_wr_fire;
  logic               w_wr_hit;
  logic [CTR_LEN-1:0] w_cur;
  logic [CTR_LEN-1:0] w_tgt;
  logic               w_imm;
  logic [CTR_LEN-1:0] w_nxt;
  logic [CTR_LEN-1:0] w_eff;
  logic [CTR_LEN-1:0] w_acc_nxt;

  // The last cycle of a PWM period. Registers updated on this edge take
  // effect together with the counter's wrap to 0.
  assign w_boundary = (r_ctr == {CTR_LEN{1'b1}});
  assign w_tick     = w_boundary && (r_div == DIV_LAST);

  assign w_wr_fire  = wr_valid && !r_busy;
  assign w_wr_hit   = (int'(wr_idx) < NUM_OUTPUTS);

  // Select the entry of the output being visited for the shared step unit.
  always_comb begin
    w_cur = '0;
    w_tgt = '0;
    w_imm = 1'b0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (r_i == IW'(k)) begin
        w_cur = r_cur[k];
        w_tgt = r_tgt[k];
        w_imm = r_imm[k];
      end
    end
  end

  pwm_fade_step #(
    .CTR_LEN   (CTR_LEN),
    .FADE_STEP (FADE_STEP)
  ) u_step (
    .i_cur (w_cur),
    .i_tgt (w_tgt),
    .i_imm (w_imm),
    .o_nxt (w_nxt),
    .o_eff (w_eff)
  );

  assign w_acc_nxt = CTR_LEN'(sat_add(duty_t'(r_acc), duty_t'(w_eff), CTR_LEN));

  // ---------------------------------------------------------------------
  // Mirrored PWM counter, period pulse and fade divider
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr          <= '0;
      r_div          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_ctr          <= r_ctr + CTR_LEN'(1);
      r_period_start <= w_boundary;
      if (w_boundary)
        r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Target table, fade pass FSM, shadow and compare registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_i          <= '0;
      r_acc        <= '0;
      r_cur        <= '0;
      r_tgt        <= '0;
      r_imm        <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_compare    <= '0;
    end else begin
      // Writes are only accepted outside a pass. They therefore never
      // collide with the pass updating r_imm.
      if (w_wr_fire && w_wr_hit) begin
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
          if (int'(wr_idx) == k) begin
            r_tgt[k] <= wr_duty;
            r_imm[k] <= r_imm[k] | wr_immediate;
          end
        end
      end

      // A completed table goes out only on a period boundary. A pass
      // cannot finish on a boundary cycle, because NUM_OUTPUTS+2 < 2**CTR_LEN.
      if (w_boundary && r_shadow_vld) begin
        r_compare    <= {r_shadow, {CTR_LEN{1'b0}}};
        r_shadow_vld <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= ACCUM;
            r_busy  <= 1'b1;
            r_i     <= '0;
            r_acc   <= '0;
          end
        end

        // A tick that arrives here is ignored. Under the parameter limits,
        // a pass ends long before the next boundary.
        ACCUM: begin
          for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (r_i == IW'(k)) begin
              r_cur[k]      <= w_nxt;
              r_imm[k]      <= 1'b0;
              r_shadow[k+1] <= w_acc_nxt;
            end
          end
          r_acc <= w_acc_nxt;
          if (r_i == I_LAST) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_shadow_vld <= 1'b1;
          end else begin
            r_i <= r_i + IW'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign compare      = r_compare;
  assign period_start = r_period_start;
  assign busy         = r_busy;
  assign wr_ready     = !r_busy;

endmodule
